// File: rtl/uart_tx_pkg.sv
// Shared definitions for the io_uart_tx memory-mapped transmitter.
// Optional parity support is selected with UART_TX_PARITY_EN.
package uart_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
      ,
      ST_PARITY = 3'd4
`endif
   } state_t;

   localparam logic [3:0] OFS_TXDATA  = 4'h0;
   localparam logic [3:0] OFS_STATUS  = 4'h4;
   localparam logic [3:0] OFS_DIVISOR = 4'h8;

   localparam logic [1:0] SEL_TXDATA  = OFS_TXDATA[3:2];
   localparam logic [1:0] SEL_STATUS  = OFS_STATUS[3:2];
   localparam logic [1:0] SEL_DIVISOR = OFS_DIVISOR[3:2];

   localparam int STB_BUSY  = 0;
   localparam int STB_FULL  = 1;
   localparam int STB_EMPTY = 2;
   localparam int STB_OVF   = 3;
   localparam int STB_CNT   = 4;

   function automatic logic [3:0] sat_cnt(input logic [31:0] c);
      return (c > 32'd15) ? 4'hF : c[3:0];
   endfunction

endpackage

// File: rtl/tx_fifo.sv
// Byte-wide synchronous FIFO feeding the UART shifter.
// A push while full is accepted only when a pop happens on the same edge.
module tx_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic [7:0]               din,
   output logic [7:0]               dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]  mem [DEPTH];
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;
   logic        do_push;
   logic        do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count   = wr_ptr - rd_ptr;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr[AW-1:0]];

   // Storage array; contents need no reset since pointers gate visibility.
   always_ff @(posedge clock) begin
      if (do_push)
         mem[wr_ptr[AW-1:0]] <= din;
   end

   // Pointer update; reset flushes the queue.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)
            rd_ptr <= rd_ptr + 1'b1;
      end
   end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter: TXDATA / STATUS / DIVISOR registers.
// Define UART_TX_PARITY_EN to add an even-parity bit before STOP.
module io_uart_tx
   import uart_tx_pkg::*;
#(
   parameter logic [31:0] IO_BASE    = 32'hFFFF_FC40,
   parameter logic [15:0] CLK_DIV    = 16'd868,
   parameter int          FIFO_DEPTH = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic        memwrite,
   output logic [31:0] read_data,
   output logic        txd,
   output logic        tx_idle
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic        hit;
   logic [1:0]  sel;
   logic        wr_tx;
   logic        wr_st;
   logic        wr_dv;

   logic [15:0] divisor;
   logic [15:0] div_m1;
   logic        ovf;

   logic [7:0]  f_dout;
   logic        f_full;
   logic        f_empty;
   logic [AW:0] f_count;
   logic        f_pop;

   state_t      state;
   state_t      state_n;
   logic [15:0] tmr;
   logic [15:0] tmr_n;
   logic [2:0]  bit_idx;
   logic [2:0]  bit_n;
   logic [7:0]  shreg;
   logic [7:0]  sh_n;
   logic        tmr_done;
   logic [31:0] status;

`ifdef UART_TX_PARITY_EN
   logic        par;
   logic        par_n;
`endif

   logic        unused_ok;
   assign unused_ok = ^{address[1:0], write_data[31:16]};

   assign hit   = (address[31:4] == IO_BASE[31:4]);
   assign sel   = address[3:2];
   assign wr_tx = hit & memwrite & (sel == SEL_TXDATA);
   assign wr_st = hit & memwrite & (sel == SEL_STATUS);
   assign wr_dv = hit & memwrite & (sel == SEL_DIVISOR);

   // A programmed divisor of zero behaves as one clock per bit.
   assign div_m1   = (divisor == 16'd0) ? 16'd0 : divisor - 16'd1;
   assign tmr_done = (tmr == 16'd0);
   assign tx_idle  = (state == ST_IDLE) & f_empty;

   tx_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (wr_tx),
      .pop   (f_pop),
      .din   (write_data[7:0]),
      .dout  (f_dout),
      .full  (f_full),
      .empty (f_empty),
      .count (f_count)
   );

   // Software-visible registers: divisor and sticky overflow.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         divisor <= CLK_DIV;
         ovf     <= 1'b0;
      end else begin
         if (wr_dv)
            divisor <= write_data[15:0];
         if (wr_tx && f_full && !f_pop)
            ovf <= 1'b1;
         else if (wr_st && write_data[STB_OVF])
            ovf <= 1'b0;
      end
   end

   // Frame state, bit timer and shifter.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         tmr     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
`ifdef UART_TX_PARITY_EN
         par     <= 1'b0;
`endif
      end else begin
         state   <= state_n;
         tmr     <= tmr_n;
         bit_idx <= bit_n;
         shreg   <= sh_n;
`ifdef UART_TX_PARITY_EN
         par     <= par_n;
`endif
      end
   end

   // Next-state logic and line level; a pop loads the next byte.
   always_comb begin
      state_n = state;
      tmr_n   = tmr;
      bit_n   = bit_idx;
      sh_n    = shreg;
      f_pop   = 1'b0;
      txd     = 1'b1;
`ifdef UART_TX_PARITY_EN
      par_n   = par;
`endif
      unique case (state)
         ST_IDLE: begin
            if (!f_empty) begin
               f_pop   = 1'b1;
               sh_n    = f_dout;
               tmr_n   = div_m1;
               state_n = ST_START;
`ifdef UART_TX_PARITY_EN
               par_n   = ^f_dout;
`endif
            end
         end
         ST_START: begin
            txd = 1'b0;
            if (tmr_done) begin
               tmr_n   = div_m1;
               bit_n   = 3'd0;
               state_n = ST_DATA;
            end else begin
               tmr_n = tmr - 16'd1;
            end
         end
         ST_DATA: begin
            txd = shreg[0];
            if (tmr_done) begin
               tmr_n = div_m1;
               sh_n  = {1'b0, shreg[7:1]};
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_n = ST_PARITY;
`else
                  state_n = ST_STOP;
`endif
               end else begin
                  bit_n = bit_idx + 3'd1;
               end
            end else begin
               tmr_n = tmr - 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            txd = par;
            if (tmr_done) begin
               tmr_n   = div_m1;
               state_n = ST_STOP;
            end else begin
               tmr_n = tmr - 16'd1;
            end
         end
`endif
         ST_STOP: begin
            txd = 1'b1;
            if (tmr_done) begin
               if (!f_empty) begin
                  f_pop   = 1'b1;
                  sh_n    = f_dout;
                  tmr_n   = div_m1;
                  state_n = ST_START;
`ifdef UART_TX_PARITY_EN
                  par_n   = ^f_dout;
`endif
               end else begin
                  state_n = ST_IDLE;
               end
            end else begin
               tmr_n = tmr - 16'd1;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   // STATUS word assembly.
   always_comb begin
      status                        = '0;
      status[STB_BUSY]              = (state != ST_IDLE);
      status[STB_FULL]              = f_full;
      status[STB_EMPTY]             = f_empty;
      status[STB_OVF]               = ovf;
      status[STB_CNT+3:STB_CNT]     = sat_cnt(32'(f_count));
   end

   // Zero-latency readback; misses and the reserved slot read zero.
   always_comb begin
      read_data = '0;
      if (hit) begin
         unique case (sel)
            SEL_TXDATA:  read_data = '0;
            SEL_STATUS:  read_data = status;
            SEL_DIVISOR: read_data = {16'd0, divisor};
            default:     read_data = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_io_uart_tx.sv
// Scoreboard bench for io_uart_tx: queued expected bytes checked by a
// line monitor that decodes every frame seen on txd.
module tb_io_uart_tx;

   localparam logic [31:0] BASE = 32'hFFFF_FC40;
   localparam logic [31:0] A_TX = BASE;
   localparam logic [31:0] A_ST = BASE + 32'd4;
   localparam logic [31:0] A_DV = BASE + 32'd8;
   localparam logic [31:0] A_RS = BASE + 32'd12;
`ifdef UART_TX_PARITY_EN
   localparam int NB = 11;
`else
   localparam int NB = 10;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        memwrite;
   logic [31:0] read_data;
   logic        txd;
   logic        tx_idle;

   int          n_chk = 0;
   int          n_fail = 0;
   int          cur_div = 868;
   logic [7:0]  exp_q [$];

   always #5 clock = ~clock;

   io_uart_tx #(
      .IO_BASE    (BASE),
      .CLK_DIV    (16'd868),
      .FIFO_DEPTH (8)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .address    (address),
      .write_data (write_data),
      .memwrite   (memwrite),
      .read_data  (read_data),
      .txd        (txd),
      .tx_idle    (tx_idle)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
      @(negedge clock);
      address    = a;
      write_data = d;
      memwrite   = 1'b1;
   endtask

   task automatic bus_rd(input logic [31:0] a, input logic [31:0] exp,
                         input string nm);
      @(negedge clock);
      memwrite = 1'b0;
      address  = a;
      #1;
      chk(nm, read_data, exp);
   endtask

   task automatic send(input logic [7:0] b);
      bus_wr(A_TX, {24'd0, b});
      exp_q.push_back(b);
   endtask

   task automatic idle(input int n);
      @(negedge clock);
      memwrite = 1'b0;
      address  = 32'd0;
      repeat (n) @(negedge clock);
   endtask

   task automatic wait_drain(input string nm, input int max);
      int c;
      c = 0;
      while (!(tx_idle && exp_q.size() == 0) && c < max) begin
         @(negedge clock);
         c++;
      end
      chk(nm, {30'd0, tx_idle, exp_q.size() == 0}, 32'd3);
   endtask

   // Line monitor: decode each frame and compare with the scoreboard.
   initial begin : monitor
      int         d;
      logic [NB-1:0] bits;
      logic       ok;
      logic       ab;
      logic       v;
      forever begin
         @(negedge clock);
         if (reset && txd === 1'b0) begin
            d    = cur_div;
            bits = '0;
            ok   = 1'b1;
            ab   = 1'b0;
            for (int k = 0; k < NB; k++) begin
               for (int j = 0; j < d; j++) begin
                  if (!(k == 0 && j == 0))
                     @(negedge clock);
                  if (!reset) begin
                     ab = 1'b1;
                     break;
                  end
                  v = txd;
                  if (j == 0)
                     bits[k] = v;
                  else if (v !== bits[k])
                     ok = 1'b0;
               end
               if (ab)
                  break;
            end
            if (!ab) begin
               if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1)
                  ok = 1'b0;
`ifdef UART_TX_PARITY_EN
               if (bits[9] !== ^bits[8:1])
                  ok = 1'b0;
`endif
               chk("frame_fmt", {31'd0, ok}, 32'd1);
               if (exp_q.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_frame: got %h expected none",
                           bits[8:1]);
               end else begin
                  chk("frame_data", {24'd0, bits[8:1]},
                      {24'd0, exp_q.pop_front()});
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin : stim
      int   c;
      logic seen_low;
      address    = 32'd0;
      write_data = 32'd0;
      memwrite   = 1'b0;

      repeat (3) @(negedge clock);
      chk("rst_txd", {31'd0, txd}, 32'd1);
      chk("rst_idle", {31'd0, tx_idle}, 32'd1);
      reset = 1'b1;
      bus_rd(A_ST, 32'h4, "status_rst");
      bus_rd(A_DV, 32'd868, "div_rst");
      bus_rd(A_TX, 32'd0, "txdata_rd");

      // Single A5 frame at 4 clocks per bit.
      bus_wr(A_DV, 32'd4);
      cur_div = 4;
      bus_rd(A_DV, 32'd4, "div_rd");
      send(8'hA5);
      @(posedge clock);
      #1;
      memwrite = 1'b0;
      chk("txd_store_edge", {31'd0, txd}, 32'd1);
      @(posedge clock);
      #1;
      chk("txd_start", {31'd0, txd}, 32'd0);
      c = 0;
      while (!tx_idle && c < 1000) begin
         @(posedge clock);
         #1;
         c++;
      end
      chk("frame_len", c, NB * 4);
      wait_drain("a5_drain", 50);

      // Fill past capacity while the first byte is in the shifter.
      bus_wr(A_DV, 32'd2);
      cur_div = 2;
      for (int i = 0; i < 10; i++) begin
         bus_wr(A_TX, 32'h10 + i);
         if (i < 9)
            exp_q.push_back(8'(8'h10 + i));
      end
      bus_rd(A_ST, 32'h8B, "status_full_ovf");
      bus_wr(A_ST, 32'h8);
      bus_rd(A_ST, 32'h83, "status_ovf_clr");
      wait_drain("ovf_drain", 400);
      bus_rd(A_ST, 32'h4, "status_drained");

      // Three frames with no idle gap between them.
      bus_wr(A_DV, 32'd4);
      cur_div = 4;
      send(8'h3C);
      send(8'hC3);
      send(8'h00);
      @(posedge clock);
      #1;
      memwrite = 1'b0;
      c = 1;
      while (!tx_idle && c < 1000) begin
         @(posedge clock);
         #1;
         c++;
      end
      chk("b2b_len", c, 3 * NB * 4);
      wait_drain("b2b_drain", 50);

      // Divisor 0 runs at one clock per bit; count starts at store edge.
      bus_wr(A_DV, 32'd0);
      cur_div = 1;
      bus_rd(A_DV, 32'd0, "div_zero_rd");
      send(8'h96);
      @(posedge clock);
      #1;
      memwrite = 1'b0;
      c = 0;
      while (!tx_idle && c < 1000) begin
         @(posedge clock);
         #1;
         c++;
      end
      chk("div0_len", c, NB + 1);
      wait_drain("div0_drain", 50);

      // Reset in the middle of the data bits of F0, 0F still queued.
      bus_wr(A_DV, 32'd4);
      cur_div = 4;
      send(8'hF0);
      send(8'h0F);
      idle(8);
      #2;
      chk("txd_pre_rst", {31'd0, txd}, 32'd0);
      reset = 1'b0;
      #1;
      chk("txd_in_rst", {31'd0, txd}, 32'd1);
      exp_q.delete();
      cur_div = 868;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      bus_rd(A_ST, 32'h4, "status_after_rst");
      bus_rd(A_DV, 32'd868, "div_after_rst");
      seen_low = 1'b0;
      repeat (100) begin
         @(negedge clock);
         if (txd !== 1'b1)
            seen_low = 1'b1;
      end
      chk("no_frame_after_rst", {31'd0, seen_low}, 32'd0);

      // Reserved slot and addresses outside the block.
      bus_rd(A_RS, 32'd0, "rsvd_rd");
      bus_rd(32'h0000_1000, 32'd0, "outside_rd");
      bus_rd(32'hFFFF_FC38, 32'd0, "neighbor_rd");
      bus_wr(A_RS, 32'hFFFF_FFFF);
      bus_wr(32'hFFFF_FC38, 32'd5);
      bus_wr(32'hFFFF_FC30, 32'h55);
      bus_wr(32'hFFFF_FC50, 32'h66);
      idle(5);
      chk("outside_idle", {31'd0, tx_idle}, 32'd1);
      bus_rd(A_DV, 32'd868, "div_unchanged");
      bus_rd(A_ST, 32'h4, "status_unchanged");
      idle(20);
      chk("queue_empty", exp_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
